vedic_mult_seq: RTL and testbench
=================================

VEDIC_MULT_SEQ -- requirements
Module: vedic_mult_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal values 8, 12, 16 (multiple of 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand pair offered.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have port a  input  WIDTH  unsigned multiplicand.
REQ-007 SHALL have port b  input  WIDTH  unsigned multiplier.
REQ-008 SHALL have port out_valid  output  1  product available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts product.
REQ-010 SHALL have port out  output  2*WIDTH  unsigned product a*b.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL compute the unsigned product by time-multiplexing one 4x4 Vedic multiplier over K=(WIDTH/4)^2 chunk pairs.
REQ-013 SHALL implement FSM states IDLE, CALC and DONE.
REQ-014 IDLE: in_ready=1. On in_valid&&in_ready, SHALL capture a and b into internal registers, clear the accumulator and chunk indices, and go to CALC.
REQ-015 CALC: each cycle SHALL multiply chunk a[4i+3:4i] by chunk b[4j+3:4j] and add the 8-bit result, shifted left by 4*(i+j), into the 2*WIDTH accumulator.
REQ-016 Index order SHALL be i outer and j inner, starting at i=j=0; j wraps to 0 and i increments when j reaches WIDTH/4-1.
REQ-017 After the K-th accumulation, SHALL go to DONE; out_valid SHALL first be high exactly K cycles after the accepting edge (K=4 for WIDTH=8).
REQ-018 Latency SHALL be fixed; no early exit on zero operands.
REQ-019 Accumulator arithmetic SHALL be 2*WIDTH bits wide; the result never overflows, so no carry-out exists.
REQ-020 DONE: out_valid=1, and out SHALL hold the final accumulator value stable until out_valid&&out_ready.
REQ-021 On out_valid&&out_ready, SHALL return to IDLE on the next edge, with out_valid=0 and in_ready=1 that cycle.
REQ-022 The earliest next accept SHALL be the cycle after the output handshake; throughput is one product per K+2 cycles with out_ready held high.
REQ-023 in_valid, a and b SHALL be ignored in CALC and DONE; captured operands SHALL NOT change.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 out SHALL retain the last product after the output handshake until the next product completes; out is meaningful only while out_valid=1.

Reset
REQ-026 When rst=1 at an edge, state SHALL become IDLE, with in_ready=1, out_valid=0, busy=0, out=0, and the accumulator, operand registers and chunk indices =0.
REQ-027 Reset asserted during CALC or DONE SHALL abort the operation with no output handshake; rst SHALL take priority over every other input.

Structure
REQ-028 Package vedic_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and the constant CHUNK_W=4.
REQ-029 SHALL instantiate exactly one existing vedic_mult_4bit as its sole sub-module; no other multiplier logic is permitted.
REQ-030 Chunk selection, shift and accumulate SHALL be local to this module; the counter width is sized from WIDTH/CHUNK_W.

Verification
REQ-031 WIDTH=8, a=0xFF, b=0xFF, out_ready=1 -> out_valid high 4 cycles after accept, out=0xFE01, in_ready high the following cycle.
REQ-032 WIDTH=8, a=0x00, b=0xA5 -> out=0x0000 with the same 4-cycle latency.
REQ-033 WIDTH=8, a=0x3C, b=0x7B, out_ready low for 3 cycles in DONE -> out=0x1CD4 held stable and out_valid high throughout; handshake on the 4th cycle; in_valid toggled with a=0x11 during CALC has no effect.
REQ-034 rst pulsed on the 2nd CALC cycle -> next cycle in IDLE, out_valid=0, out=0; subsequent a=0x02, b=0x03 -> out=0x0006.
REQ-035 WIDTH=16, a=0xFFFF, b=0xFFFF -> out=0xFFFE0001 16 cycles after accept; back-to-back second pair a=0x1234, b=0x0010 -> out=0x00012340.
REQ-036 Random regression of 1000 pairs per legal WIDTH with random out_ready backpressure -> every out equals a*b, in order.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared types and helpers for the sequential Vedic multiplier.
// Holds the FSM state encoding, the chunk width and the 2x2 Urdhva-Tiryagbhyam cell.
package vedic_pkg;

  localparam int CHUNK_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Vertical-and-crosswise 2x2 product built from AND gates and half adders.
  function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
    logic t0, t1, t2, t3, c1;
    logic [3:0] r;
    t0 = x[0] & y[0];
    t1 = x[1] & y[0];
    t2 = x[0] & y[1];
    t3 = x[1] & y[1];
    c1 = t1 & t2;
    r[0] = t0;
    r[1] = t1 ^ t2;
    r[2] = t3 ^ c1;
    r[3] = t3 & c1;
    return r;
  endfunction

endpackage

// File: rtl/vedic_mult_4bit.sv
// Combinational 4x4 Vedic multiplier assembled from four 2x2 vertical-and-crosswise cells.
module vedic_mult_4bit
  import vedic_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [3:0] p_ll;
  logic [3:0] p_hl;
  logic [3:0] p_lh;
  logic [3:0] p_hh;
  logic [4:0] cross_sum;

  assign p_ll = vedic_2x2(a[1:0], b[1:0]);
  assign p_hl = vedic_2x2(a[3:2], b[1:0]);
  assign p_lh = vedic_2x2(a[1:0], b[3:2]);
  assign p_hh = vedic_2x2(a[3:2], b[3:2]);

  // The two crosswise terms share weight 4, so they are summed before alignment.
  assign cross_sum = {1'b0, p_hl} + {1'b0, p_lh};
  assign p = {4'b0000, p_ll} + {1'b0, cross_sum, 2'b00} + {p_hh, 4'b0000};

endmodule

// File: rtl/vedic_mult_seq.sv
// Sequential unsigned multiplier that walks all 4-bit chunk pairs of a and b
// through a single 4x4 Vedic cell, accumulating shifted partial products.
module vedic_mult_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int NCH   = WIDTH / CHUNK_W;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int ACC_W = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   out_q, out_d;
  logic [IDX_W-1:0]   i_q, i_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [CHUNK_W-1:0] a_chunk;
  logic [CHUNK_W-1:0] b_chunk;
  logic [7:0]         prod;
  logic [IDX_W:0]     idx_sum;
  logic [ACC_W-1:0]   partial;

  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int k = 0; k < NCH; k++) begin
      if (i_q == IDX_W'(k)) a_chunk = a_q[k*CHUNK_W +: CHUNK_W];
      if (j_q == IDX_W'(k)) b_chunk = b_q[k*CHUNK_W +: CHUNK_W];
    end
  end

  vedic_mult_4bit u_mult (
    .a (a_chunk),
    .b (b_chunk),
    .p (prod)
  );

  // Chunk pair (i, j) carries weight 2^(4*(i+j)).
  assign idx_sum = {1'b0, i_q} + {1'b0, j_q};
  assign partial = ACC_W'(prod) << {idx_sum, 2'b00};

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_d       = out_q;
    i_d         = i_q;
    j_d         = j_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          acc_d      = '0;
          i_d        = '0;
          j_d        = '0;
          state_d    = CALC;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      CALC: begin
        acc_d = acc_q + partial;
        if (i_q == LAST_IDX && j_q == LAST_IDX) begin
          out_d       = acc_q + partial;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (j_q == LAST_IDX) begin
          j_d = '0;
          i_d = i_q + 1'b1;
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      i_q         <= '0;
      j_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_q       <= out_d;
      i_q         <= i_d;
      j_q         <= j_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Scoreboard bench for vedic_mult_seq at WIDTH 8, 12 and 16 sharing one stimulus bus.
module tb_vedic_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [15:0] a_bus;
  logic [15:0] b_bus;
  int          sel;
  int          cyc = 0;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] exp_q[$];

  logic        in_ready8, out_valid8, busy8;
  logic [15:0] out8;
  logic        in_ready12, out_valid12, busy12;
  logic [23:0] out12;
  logic        in_ready16, out_valid16, busy16;
  logic [31:0] out16;

  logic        obs_in_ready, obs_out_valid, obs_busy;
  logic [31:0] obs_out;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vedic_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && (sel == 0)), .in_ready(in_ready8),
    .a(a_bus[7:0]), .b(b_bus[7:0]),
    .out_valid(out_valid8), .out_ready(out_ready && (sel == 0)),
    .out(out8), .busy(busy8)
  );

  vedic_mult_seq #(.WIDTH(12)) dut12 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && (sel == 1)), .in_ready(in_ready12),
    .a(a_bus[11:0]), .b(b_bus[11:0]),
    .out_valid(out_valid12), .out_ready(out_ready && (sel == 1)),
    .out(out12), .busy(busy12)
  );

  vedic_mult_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid && (sel == 2)), .in_ready(in_ready16),
    .a(a_bus), .b(b_bus),
    .out_valid(out_valid16), .out_ready(out_ready && (sel == 2)),
    .out(out16), .busy(busy16)
  );

  always_comb begin
    obs_in_ready  = in_ready8;
    obs_out_valid = out_valid8;
    obs_busy      = busy8;
    obs_out       = {16'h0000, out8};
    case (sel)
      1: begin
        obs_in_ready  = in_ready12;
        obs_out_valid = out_valid12;
        obs_busy      = busy12;
        obs_out       = {8'h00, out12};
      end
      2: begin
        obs_in_ready  = in_ready16;
        obs_out_valid = out_valid16;
        obs_busy      = busy16;
        obs_out       = out16;
      end
      default: ;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int k_of(input int s);
    return (s == 0) ? 4 : ((s == 1) ? 9 : 16);
  endfunction

  function automatic logic [31:0] model(input int s, input logic [15:0] av, input logic [15:0] bv);
    logic [15:0] m;
    logic [31:0] x, y;
    m = (s == 0) ? 16'h00FF : ((s == 1) ? 16'h0FFF : 16'hFFFF);
    x = {16'h0000, av & m};
    y = {16'h0000, bv & m};
    return x * y;
  endfunction

  // Drives one operand pair through the selected DUT and returns what came out.
  task automatic do_op(input int s, input logic [15:0] av, input logic [15:0] bv,
                       input int stall, output int lat, output logic [31:0] got,
                       output int acc_cyc, output bit to);
    int n;
    sel = s;
    to = 1'b0;
    a_bus = av;
    b_bus = bv;
    out_ready = 1'b0;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!obs_in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!obs_in_ready) to = 1'b1;
    tick();
    acc_cyc = cyc;
    in_valid = 1'b0;
    exp_q.push_back(model(s, av, bv));
    lat = 0;
    while (!obs_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    if (!obs_out_valid) to = 1'b1;
    repeat (stall) tick();
    out_ready = 1'b1;
    got = obs_out;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a_bus = '0;
    b_bus = '0;
    sel = 0;
    tick();
    tick();
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      tests_run++;
      if (obs_in_ready !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL reset_in_ready w%0d: got %b expected 1", s, obs_in_ready);
      end
      tests_run++;
      if (obs_out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_out_valid w%0d: got %b expected 0", s, obs_out_valid);
      end
      tests_run++;
      if (obs_busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL reset_busy w%0d: got %b expected 0", s, obs_busy);
      end
      tests_run++;
      if (obs_out !== 32'h0) begin
        tests_failed++;
        $display("[TB] FAIL reset_out w%0d: got %h expected 0", s, obs_out);
      end
    end
  endtask

  task automatic test_full_ones();
    int lat, ac;
    logic [31:0] got, exp_v;
    bit to;
    do_op(0, 16'h00FF, 16'h00FF, 0, lat, got, ac, to);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (to || lat != 4) begin
      tests_failed++;
      $display("[TB] FAIL ones_latency: got %0d expected 4 (timeout=%0d)", lat, to);
    end
    tests_run++;
    if (got !== exp_v || got !== 32'h0000FE01) begin
      tests_failed++;
      $display("[TB] FAIL ones_product: got %h expected %h", got, exp_v);
    end
    tests_run++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ones_after_handshake: got ready=%b valid=%b busy=%b expected 1 0 0",
               obs_in_ready, obs_out_valid, obs_busy);
    end
    tests_run++;
    if (obs_out !== 32'h0000FE01) begin
      tests_failed++;
      $display("[TB] FAIL ones_out_retained: got %h expected 0000fe01", obs_out);
    end
  endtask

  task automatic test_zero();
    int lat, ac;
    logic [31:0] got, exp_v;
    bit to;
    do_op(0, 16'h0000, 16'h00A5, 0, lat, got, ac, to);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (to || lat != 4) begin
      tests_failed++;
      $display("[TB] FAIL zero_latency: got %0d expected 4 (timeout=%0d)", lat, to);
    end
    tests_run++;
    if (got !== exp_v) begin
      tests_failed++;
      $display("[TB] FAIL zero_product: got %h expected %h", got, exp_v);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] got, exp_v;
    sel = 0;
    a_bus = 16'h003C;
    b_bus = 16'h007B;
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    exp_q.push_back(model(0, 16'h003C, 16'h007B));
    tests_run++;
    if (obs_busy !== 1'b1 || obs_in_ready !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_accept: got busy=%b ready=%b expected 1 0", obs_busy, obs_in_ready);
    end
    a_bus = 16'h0011;
    b_bus = 16'h0011;
    tick();
    in_valid = 1'b0;
    tick();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 3;
    while (!obs_out_valid && lat < 40) begin
      tick();
      lat++;
    end
    tests_run++;
    if (lat != 4) begin
      tests_failed++;
      $display("[TB] FAIL bp_latency: got %0d expected 4", lat);
    end
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if (obs_out_valid !== 1'b1 || obs_out !== exp_q[0]) begin
        tests_failed++;
        $display("[TB] FAIL bp_hold%0d: got valid=%b out=%h expected 1 %h", c, obs_out_valid, obs_out, exp_q[0]);
      end
      tick();
    end
    out_ready = 1'b1;
    tests_run++;
    if (obs_out_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL bp_valid_at_handshake: got %b expected 1", obs_out_valid);
    end
    got = obs_out;
    tick();
    out_ready = 1'b0;
    exp_v = exp_q.pop_front();
    tests_run++;
    if (got !== exp_v || got !== 32'h00001CD4) begin
      tests_failed++;
      $display("[TB] FAIL bp_product: got %h expected %h", got, exp_v);
    end
    tests_run++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL bp_idle: got ready=%b valid=%b expected 1 0", obs_in_ready, obs_out_valid);
    end
  endtask

  task automatic test_reset_abort();
    int lat, ac, seen;
    logic [31:0] got, exp_v;
    bit to;
    sel = 0;
    a_bus = 16'h0055;
    b_bus = 16'h0055;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if (obs_in_ready !== 1'b1 || obs_out_valid !== 1'b0 || obs_busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL abort_state: got ready=%b valid=%b busy=%b expected 1 0 0",
               obs_in_ready, obs_out_valid, obs_busy);
    end
    tests_run++;
    if (obs_out !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL abort_out: got %h expected 0", obs_out);
    end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (obs_out_valid) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      tests_failed++;
      $display("[TB] FAIL abort_no_output: got %0d valid cycles expected 0", seen);
    end
    do_op(0, 16'h0002, 16'h0003, 1, lat, got, ac, to);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (to || got !== exp_v || got !== 32'h6) begin
      tests_failed++;
      $display("[TB] FAIL abort_next_product: got %h expected %h (timeout=%0d)", got, exp_v, to);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, ac1, ac2;
    logic [31:0] got1, got2, exp_v;
    bit to1, to2;
    do_op(2, 16'hFFFF, 16'hFFFF, 0, lat1, got1, ac1, to1);
    do_op(2, 16'h1234, 16'h0010, 0, lat2, got2, ac2, to2);
    exp_v = exp_q.pop_front();
    tests_run++;
    if (to1 || got1 !== exp_v || got1 !== 32'hFFFE0001) begin
      tests_failed++;
      $display("[TB] FAIL b2b_first: got %h expected %h (timeout=%0d)", got1, exp_v, to1);
    end
    tests_run++;
    if (lat1 != 16 || lat2 != 16) begin
      tests_failed++;
      $display("[TB] FAIL b2b_latency: got %0d/%0d expected 16/16", lat1, lat2);
    end
    exp_v = exp_q.pop_front();
    tests_run++;
    if (to2 || got2 !== exp_v || got2 !== 32'h00012340) begin
      tests_failed++;
      $display("[TB] FAIL b2b_second: got %h expected %h (timeout=%0d)", got2, exp_v, to2);
    end
    tests_run++;
    if (ac2 - ac1 != 18) begin
      tests_failed++;
      $display("[TB] FAIL b2b_throughput: got %0d cycles expected 18", ac2 - ac1);
    end
  endtask

  task automatic test_random();
    int lat, ac;
    logic [31:0] got, exp_v;
    logic [15:0] av, bv;
    bit to;
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 1000; n++) begin
        av = 16'($urandom);
        bv = 16'($urandom);
        if (n % 97 == 0) av = 16'hFFFF;
        if (n % 89 == 0) bv = 16'h0000;
        do_op(s, av, bv, $urandom_range(0, 3), lat, got, ac, to);
        exp_v = exp_q.pop_front();
        tests_run++;
        if (to || lat != k_of(s) || got !== exp_v) begin
          tests_failed++;
          $display("[TB] FAIL random w%0d #%0d a=%h b=%h: got %h lat %0d expected %h lat %0d",
                   s, n, av, bv, got, lat, exp_v, k_of(s));
        end
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_full_ones();
    test_zero();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
